// File: rtl/sync_event_pkg.sv
// sync_event_pkg: shared types and helpers for the sync_event input conditioner.
// Optional feature macro: SYNC_EVENT_DEBOUNCE_EN (used by sync_event_ch).
package sync_event_pkg;

  // Width of one channel's mode field inside mode_i.
  localparam int MODE_W = 2;

  // Which stable-level edge(s) produce an event pulse.
  typedef enum logic [MODE_W-1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Returns 1 when the edge seen this cycle is one the mode selects.
  function automatic logic edge_hit(edge_mode_t mode, logic rise, logic fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_NONE: hit = 1'b0;
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_event_ch.sv
// sync_event_ch: one input channel -- synchronizer chain, optional debounce,
// edge detection, mode-selected event pulse and sticky event/overflow flags.
// Optional feature macro: SYNC_EVENT_DEBOUNCE_EN. When undefined the stable
// level simply follows the last synchronizer stage (one-cycle filter).
module sync_event_ch
  import sync_event_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter int   DB_CYCLES = 16,
  parameter logic INIT      = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              async_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              clr_i,
  output logic              level_o,
  output logic              rise_o,
  output logic              fall_o,
  output logic              evt_o,
  output logic              flag_o,
  output logic              ovf_o
);

  // Elaboration-time parameter sanity checks.
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_event_ch: STAGES must be >= 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("sync_event_ch: DB_CYCLES must be >= 1");
  end

  logic [STAGES-1:0] r_sync;
  logic              w_s;
  logic              w_upd;
  logic              w_rise;
  logic              w_fall;
  logic              w_evt;
  logic              w_flag_nxt;
  logic              w_ovf_nxt;
  logic              r_level;
  logic              r_rise;
  logic              r_fall;
  logic              r_evt;
  logic              r_flag;
  logic              r_ovf;

  // Synchronizer chain: the first flop is the only one exposed to async_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= {STAGES{INIT}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], async_i};
    end
  end

  assign w_s = r_sync[STAGES-1];

`ifdef SYNC_EVENT_DEBOUNCE_EN
  // Counter never needs to hold DB_CYCLES itself; it wraps at DB_CYCLES-1.
  localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Debounce: accept the new level only after DB_CYCLES consecutive mismatches.
  always_comb begin
    w_cnt_nxt = '0;
    w_upd     = 1'b0;
    if (w_s != r_level) begin
      if (r_cnt == CNT_LAST) begin
        w_upd     = 1'b1;
        w_cnt_nxt = '0;
      end else begin
        w_upd     = 1'b0;
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else begin
      w_upd     = 1'b0;
      w_cnt_nxt = '0;
    end
  end

  // Debounce counter register; a reset discards any partial count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  // Without debounce the stable level tracks the synchronizer every cycle.
  assign w_upd = (w_s != r_level);
`endif

  // Edge, event and sticky-flag next-state logic.
  always_comb begin
    w_rise     = 1'b0;
    w_fall     = 1'b0;
    w_evt      = 1'b0;
    w_flag_nxt = 1'b0;
    w_ovf_nxt  = 1'b0;
    if (w_upd) begin
      w_rise = w_s;
      w_fall = ~w_s;
    end else begin
      w_rise = 1'b0;
      w_fall = 1'b0;
    end
    w_evt = edge_hit(edge_mode_t'(mode_i), w_rise, w_fall);
    // Clear is applied first, a coincident event then re-sets the flag.
    if (clr_i) begin
      w_flag_nxt = w_evt;
      w_ovf_nxt  = 1'b0;
    end else begin
      w_flag_nxt = r_flag | w_evt;
      w_ovf_nxt  = r_ovf | (w_evt & r_flag);
    end
  end

  // Output registers: level, one-cycle pulses and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_level <= INIT;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_evt   <= 1'b0;
      r_flag  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_upd) begin
        r_level <= w_s;
      end else begin
        r_level <= r_level;
      end
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_evt  <= w_evt;
      r_flag <= w_flag_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign evt_o   = r_evt;
  assign flag_o  = r_flag;
  assign ovf_o   = r_ovf;

endmodule

// File: rtl/sync_event.sv
// sync_event: multi-channel asynchronous input conditioner. Each channel is
// an independent sync_event_ch; this top only slices the vector ports.
// Optional feature macro: SYNC_EVENT_DEBOUNCE_EN (debounce counters).
module sync_event
  import sync_event_pkg::*;
#(
  parameter int            CH        = 4,
  parameter int            STAGES    = 2,
  parameter int            DB_CYCLES = 16,
  parameter logic [CH-1:0] INIT      = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CH-1:0]        async_i,
  input  logic [MODE_W*CH-1:0] mode_i,
  input  logic [CH-1:0]        clr_i,
  output logic [CH-1:0]        level_o,
  output logic [CH-1:0]        rise_o,
  output logic [CH-1:0]        fall_o,
  output logic [CH-1:0]        evt_o,
  output logic [CH-1:0]        flag_o,
  output logic [CH-1:0]        ovf_o
);

  // Elaboration-time parameter sanity check.
  if (CH < 1) begin : g_bad_ch
    $error("sync_event: CH must be >= 1");
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    sync_event_ch #(
      .STAGES    (STAGES),
      .DB_CYCLES (DB_CYCLES),
      .INIT      (INIT[c])
    ) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .async_i (async_i[c]),
      .mode_i  (mode_i[MODE_W*c +: MODE_W]),
      .clr_i   (clr_i[c]),
      .level_o (level_o[c]),
      .rise_o  (rise_o[c]),
      .fall_o  (fall_o[c]),
      .evt_o   (evt_o[c]),
      .flag_o  (flag_o[c]),
      .ovf_o   (ovf_o[c])
    );
  end

endmodule

// File: tb/tb_sync_event.sv
// tb_sync_event: directed and randomized checks of sync_event against a
// behavioural model (delay line + run-length debounce + flag rules).
`timescale 1ns/1ps
module tb_sync_event;
  import sync_event_pkg::*;

  localparam int            CH        = 4;
  localparam int            STAGES    = 2;
  localparam int            DB_CYCLES = 4;
  localparam logic [CH-1:0] INIT      = '0;
`ifdef SYNC_EVENT_DEBOUNCE_EN
  localparam int DB_EFF = DB_CYCLES;
`else
  localparam int DB_EFF = 1;
`endif
  localparam int LAT = STAGES + DB_EFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     async_in;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     clr;
  logic [CH-1:0]     level_o, rise_o, fall_o, evt_o, flag_o, ovf_o;
  logic [6*CH-1:0]   dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  sync_event #(
    .CH(CH), .STAGES(STAGES), .DB_CYCLES(DB_CYCLES), .INIT(INIT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .async_i(async_in), .mode_i(mode), .clr_i(clr),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .evt_o(evt_o),
    .flag_o(flag_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  assign dut_vec = {ovf_o, flag_o, evt_o, fall_o, rise_o, level_o};

  // ---------------- behavioural model ----------------
  logic [CH-1:0] dly_q[$];
  logic [CH-1:0] m_level, m_rise, m_fall, m_evt, m_flag, m_ovf;
  int            m_run[CH];

  task automatic model_reset();
    dly_q.delete();
    for (int i = 0; i < STAGES; i++) dly_q.push_back(INIT);
    m_level = INIT;
    m_rise = '0; m_fall = '0; m_evt = '0; m_flag = '0; m_ovf = '0;
    for (int c = 0; c < CH; c++) m_run[c] = 0;
  endtask

  task automatic model_step();
    logic [CH-1:0] s;
    logic ev;
    s = dly_q.pop_front();
    dly_q.push_back(async_in);
    m_rise = '0; m_fall = '0; m_evt = '0;
    for (int c = 0; c < CH; c++) begin
      if (s[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == DB_EFF) begin
          m_level[c] = s[c];
          m_run[c] = 0;
          if (s[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
        end
      end else begin
        m_run[c] = 0;
      end
      ev = (m_rise[c] & mode[2*c]) | (m_fall[c] & mode[2*c+1]);
      m_evt[c] = ev;
      if (clr[c]) begin
        m_ovf[c]  = 1'b0;
        m_flag[c] = ev;
      end else begin
        if (ev && m_flag[c]) m_ovf[c] = 1'b1;
        if (ev) m_flag[c] = 1'b1;
      end
    end
  endtask

  function automatic logic [6*CH-1:0] exp_vec();
    return {m_ovf, m_flag, m_evt, m_fall, m_rise, m_level};
  endfunction

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int pulses;
    logic [6*CH-1:0] rst_exp;
    rst_exp = {{(5*CH){1'b0}}, INIT};
    rst_n = 1'b0; async_in = '0; mode = '0; clr = '0;
    model_reset();
    repeat (3) tick();
    n_checks++;
    if (dut_vec !== rst_exp) $display("FAIL reset_state: got %h want %h", dut_vec, rst_exp);
    else n_pass++;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      pulses += $countones(rise_o | fall_o | evt_o | flag_o);
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL idle_model cyc %0d: got %h want %h", k, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL idle_pulses: got %0d want 0", pulses);
    else n_pass++;
  endtask

  task automatic test_latency();
    mode[1:0] = EDGE_RISE;
    async_in[0] = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL latency_model edge %0d: got %h want %h", k, dut_vec, exp_vec());
      else n_pass++;
      if (k == LAT - 1) begin
        n_checks++;
        if (level_o[0] !== 1'b0) $display("FAIL latency_early edge %0d: level %b want 0", k, level_o[0]);
        else n_pass++;
      end
      if (k == LAT) begin
        n_checks++;
        if ({level_o[0], rise_o[0], evt_o[0], flag_o[0]} !== 4'b1111)
          $display("FAIL latency_edge edge %0d: lvl/rise/evt/flag %b want 1111", k,
                   {level_o[0], rise_o[0], evt_o[0], flag_o[0]});
        else n_pass++;
      end
      if (k == LAT + 1) begin
        n_checks++;
        if ({rise_o[0], evt_o[0], flag_o[0]} !== 3'b001)
          $display("FAIL latency_pulse_width: rise/evt/flag %b want 001", {rise_o[0], evt_o[0], flag_o[0]});
        else n_pass++;
      end
    end
  endtask

  task automatic test_debounce();
    int rises, falls;
`ifdef SYNC_EVENT_DEBOUNCE_EN
    rises = 0;
    async_in[2] = 1'b1;
    repeat (DB_EFF - 1) tick();
    async_in[2] = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      tick();
      rises += rise_o[2] + fall_o[2];
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL glitch_model cyc %0d: got %h want %h", k, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (rises !== 0 || level_o[2] !== 1'b0) $display("FAIL glitch_reject: edges %0d level %b want 0 0", rises, level_o[2]);
    else n_pass++;
`endif
    rises = 0; falls = 0;
    async_in[2] = 1'b1;
    for (int k = 0; k < DB_EFF; k++) begin
      tick();
      rises += rise_o[2]; falls += fall_o[2];
    end
    async_in[2] = 1'b0;
    for (int k = 0; k < 2 * LAT + 4; k++) begin
      tick();
      rises += rise_o[2]; falls += fall_o[2];
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL pulse_model cyc %0d: got %h want %h", k, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (rises !== 1 || falls !== 1) $display("FAIL min_pulse_edges: rise %0d fall %0d want 1 1", rises, falls);
    else n_pass++;
  endtask

  task automatic test_overflow();
    mode[3:2] = EDGE_FALL;
    async_in[1] = 1'b1;
    repeat (LAT + 2) tick();
    n_checks++;
    if (flag_o[1] !== 1'b0) $display("FAIL ovf_rise_ignored: flag %b want 0", flag_o[1]);
    else n_pass++;
    async_in[1] = 1'b0;
    repeat (LAT + 1) tick();
    n_checks++;
    if ({flag_o[1], ovf_o[1]} !== 2'b10) $display("FAIL ovf_first_fall: flag/ovf %b want 10", {flag_o[1], ovf_o[1]});
    else n_pass++;
    async_in[1] = 1'b1;
    repeat (LAT + 2) tick();
    async_in[1] = 1'b0;
    repeat (LAT + 1) tick();
    n_checks++;
    if ({flag_o[1], ovf_o[1]} !== 2'b11) $display("FAIL ovf_second_fall: flag/ovf %b want 11", {flag_o[1], ovf_o[1]});
    else n_pass++;
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    n_checks++;
    if ({flag_o[1], ovf_o[1]} !== 2'b00) $display("FAIL ovf_clear: flag/ovf %b want 00", {flag_o[1], ovf_o[1]});
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL ovf_model: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_clr_coincide();
    mode[3:2] = EDGE_BOTH;
    async_in[1] = 1'b1;
    repeat (LAT) tick();
    n_checks++;
    if ({evt_o[1], flag_o[1]} !== 2'b11) $display("FAIL coincide_setup: evt/flag %b want 11", {evt_o[1], flag_o[1]});
    else n_pass++;
    async_in[1] = 1'b0;
    repeat (LAT - 1) tick();
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    n_checks++;
    if ({evt_o[1], flag_o[1], ovf_o[1]} !== 3'b110)
      $display("FAIL coincide_clr: evt/flag/ovf %b want 110", {evt_o[1], flag_o[1], ovf_o[1]});
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL coincide_model: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_both_none();
    int evt2, rise3, fall3, evt3, flag3;
    evt2 = 0; rise3 = 0; fall3 = 0; evt3 = 0; flag3 = 0;
    mode[5:4] = EDGE_BOTH;
    mode[7:6] = EDGE_NONE;
    async_in[3:2] = 2'b11;
    for (int k = 0; k < 2 * (LAT + 3); k++) begin
      if (k == LAT + 3) async_in[3:2] = 2'b00;
      tick();
      evt2 += evt_o[2]; rise3 += rise_o[3]; fall3 += fall_o[3];
      evt3 += evt_o[3]; flag3 += flag_o[3];
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL both_none_model cyc %0d: got %h want %h", k, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (evt2 !== 2) $display("FAIL both_evt_count: got %0d want 2", evt2);
    else n_pass++;
    n_checks++;
    if ({rise3, fall3, evt3, flag3} !== {32'd1, 32'd1, 32'd0, 32'd0})
      $display("FAIL none_edges: rise %0d fall %0d evt %0d flag %0d want 1 1 0 0", rise3, fall3, evt3, flag3);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [6*CH-1:0] rst_exp;
    rst_exp = {{(5*CH){1'b0}}, INIT};
    mode[7:6] = EDGE_RISE;
    async_in[3] = 1'b1;
    repeat (LAT - 1) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== rst_exp) $display("FAIL midreset_async: got %h want %h", dut_vec, rst_exp);
    else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL midreset_model edge %0d: got %h want %h", k, dut_vec, exp_vec());
      else n_pass++;
      if (k == LAT - 1) begin
        n_checks++;
        if (rise_o[3] !== 1'b0 || level_o[3] !== 1'b0) $display("FAIL midreset_early: rise %b level %b want 0 0", rise_o[3], level_o[3]);
        else n_pass++;
      end
      if (k == LAT) begin
        n_checks++;
        if ({level_o[3], rise_o[3], evt_o[3]} !== 3'b111) $display("FAIL midreset_rise: lvl/rise/evt %b want 111", {level_o[3], rise_o[3], evt_o[3]});
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(3, 0) == 0) async_in[c] = ~async_in[c];
        clr[c] = ($urandom_range(9, 0) == 0);
      end
      if ($urandom_range(19, 0) == 0) mode = 8'($urandom);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL random_model cyc %0d: got %h want %h", k, dut_vec, exp_vec());
      else n_pass++;
    end
    clr = '0;
  endtask

  initial begin
    rst_n = 1'b0; async_in = '0; mode = '0; clr = '0;
    test_reset();
    test_latency();
    test_debounce();
    test_overflow();
    test_clr_coincide();
    test_both_none();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_event.md
# sync_event

Multi-channel input conditioner that brings asynchronous single-bit signals (buttons, external strobes, flags from unrelated logic) into one clock domain. Each channel has a configurable-depth synchronizer, optional debounce, rise/fall detection, a mode-selected event pulse, and sticky event/overflow flags with per-channel clear. It sits at the board-input boundary of the display/control designs, upstream of any logic that consumes external events.

## Interface
- `CH`, 4: number of independent channels (≥1).
- `STAGES`, 2: synchronizer flops per channel (≥2).
- `DB_CYCLES`, 16: debounce length in clocks (≥1); used only when debounce is compiled in.
- `INIT`, `'0`: CH-bit reset value of every channel's synchronizer chain and stable level.

- `clk_i` in 1: the single clock; all logic is in this domain.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `async_i` in CH: asynchronous inputs, no timing relationship to `clk_i`.
- `mode_i` in 2*CH: per-channel event mode, bits [2c+1:2c] for channel c; synchronous.
- `clr_i` in CH: per-channel clear of `flag_o`/`ovf_o`; synchronous, level-sensitive.
- `level_o` out CH: synchronized (and debounced) stable level.
- `rise_o` out CH: one-cycle pulse on stable 0→1.
- `fall_o` out CH: one-cycle pulse on stable 1→0.
- `evt_o` out CH: one-cycle pulse when the edge selected by the mode occurs.
- `flag_o` out CH: sticky event-pending flag.
- `ovf_o` out CH: sticky overflow; an event arrived while `flag_o` was already set.

## Operation
- Per channel: `async_i[c]` → STAGES-flop chain → last stage `s` compared against the stable register `level_q`.
- Mismatch (`s != level_q`): debounce counter increments; when counter equals DB_CYCLES−1 and mismatch persists, `level_q <= s`, counter → 0.
- Match: counter → 0. Any mismatch shorter than DB_CYCLES consecutive cycles at `s` is discarded.
- `rise_o`, `fall_o` registered, asserted on the same edge `level_q` changes, for exactly one cycle.
- Mode (from package): NONE 00, RISE 01, FALL 10, BOTH 11. `evt_o` = registered `(rise & mode[0]) | (fall & mode[1])`, evaluated with `mode_i` at the updating edge.
- `flag_o`: set on the edge `evt_o` asserts; cleared by `clr_i` when no event on that edge.
- `ovf_o`: set when an event occurs while `flag_o`=1 and `clr_i`=0; cleared by `clr_i`.
- Event and `clr_i` on the same edge: `flag_o`=1, `ovf_o`=0 (clear applies first, event wins).
- Mode change takes effect at the next edge; it never generates an event by itself.
- Counter width `$clog2(DB_CYCLES+1)`; saturation impossible because the counter resets at DB_CYCLES−1.

## Timing
- Reset (`rst_ni`=0, asynchronous): chain and `level_o` = INIT; counters, `rise_o`, `fall_o`, `evt_o`, `flag_o`, `ovf_o` = 0.
- Inputs differing from INIT at reset release are reported as a normal edge after full latency.
- Latency: input change meeting setup before edge 1 → `level_o`/edge pulses after edge STAGES+DB_CYCLES (STAGES+1 when debounce is compiled out).
- `flag_o` visible on the same edge as `evt_o`; `clr_i` effective on the next edge.
- Reset mid-debounce discards the partial count; no pulse is emitted.
- Channels are fully independent; simultaneous events on several channels are all reported.

## Configuration
- `SYNC_EVENT_DEBOUNCE_EN` defined: debounce counters present, behaviour as above.
- Not defined: no counters; `level_q <= s` every cycle (equivalent to DB_CYCLES=1); DB_CYCLES ignored; latency STAGES+1.

## Structure
- `sync_event_pkg`: `edge_mode_t` enum (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH), mode field width constant.
- Sub-module `sync_event_ch`: one channel (chain, debounce, edge, flags); top is a generate loop over CH plus port slicing.

## Test plan
- Reset with INIT=0, `async_i`=0 → all outputs 0; release, input idle 100 cycles → no pulses.
- STAGES=2, DB_CYCLES=4, ch0 mode RISE, `async_i[0]` 0→1 before edge 1 → `level_o[0]`, `rise_o[0]`, `evt_o[0]` high after edge 6, pulses one cycle, `flag_o[0]`=1.
- Debounce: 3-cycle high glitch with DB_CYCLES=4 → no level change, no pulses; 4-cycle high → exactly one rise and, on return low, one fall.
- ch1 mode FALL: two falls with no clear → `flag_o[1]`=1, `ovf_o[1]`=1 at second; `clr_i[1]` one cycle → both 0 next edge.
- Event coinciding with `clr_i` → `flag_o`=1, `ovf_o`=0; mode BOTH on ch2 → `evt_o` on both edges; mode NONE → edges on `rise_o`/`fall_o` only, no `evt_o`/flag.
- `rst_ni` asserted mid-debounce with `async_i`=1 → outputs to INIT immediately; after release, rise reported after full latency.
